mux_nto1_rr_reg: RTL and testbench
==================================

// Module: mux_nto1_rr_reg
// PURPOSE
// - Parametrised, registered successor to the 4-bit 4:1 gate-level mux: CH channels of WIDTH bits each.
// - Each input channel has a valid/ready handshake; the block selects one channel per transfer into a one-deep output register.
// - Two select modes: static (external select S, as in the combinational mux) and round-robin (fair rotation across valid channels).
// - Sits between several producer channels and a single downstream consumer that can stall.
// PARAMETERS
// - WIDTH  default 4  bits per channel word
// - CH     default 4  number of input channels; must be >= 2
// - SELW   default 2  select/channel-index width; must equal $clog2(CH)
// PORTS
// - clk       in   1         clock; all state updates on rising edge
// - rst       in   1         reset; one clock, reset is synchronous and active-high
// - I         in   CH*WIDTH  packed channel data; channel k = I[k*WIDTH +: WIDTH]
// - in_valid  in   CH        channel k has a word on I
// - in_ready  out  CH        one-hot (or zero); word on channel k is consumed this cycle
// - mode      in   1         0 = static select by S; 1 = round-robin
// - S         in   SELW      channel index used when mode=0
// - f         out  WIDTH     registered output word
// - f_valid   out  1         f holds an unconsumed word
// - f_ch      out  SELW      index of the channel that supplied f
// - f_ready   in   1         downstream accepts f this cycle
// BEHAVIOUR
// - Reset (rst=1 at clock edge): f=0, f_valid=0, f_ch=0, rr pointer=CH-1, so channel 0 has top priority first. in_ready=0 while rst=1.
// - load = !f_valid || f_ready: output register can take a new word this cycle.
// - Grant (combinational):
//   - mode=0: grant = S if in_valid[S], else none; S >= CH grants none.
//   - mode=1: first valid channel searching ptr+1, ptr+2, ... (mod CH), wrapping past CH-1 to 0.
// - in_ready[g] = load && grant valid; all other bits 0. Never more than one bit set.
// - Transfer on edge when in_ready[g]=1:
//   - f <= word g; f_ch <= g; f_valid <= 1.
//   - In mode=1 only, ptr <= g. In mode=0, ptr is unchanged.
// - Output drain: if f_valid && f_ready and no grant, then f_valid <= 0. f and f_ch hold their last value.
// - Simultaneous drain and load: the new word replaces the old in the same edge, giving full throughput of 1 word/cycle.
// - Stall: while f_valid && !f_ready, f, f_ch and f_valid are held stable, and all in_ready=0 regardless of mode, S or in_valid changes.
// - Latency: input word appears on f one cycle after its in_ready/in_valid handshake.
// - Mode or S change: takes effect on the next grant decision. A word already in f is unaffected; no word is lost or duplicated.
// - Round-robin fairness: with all channels valid continuously and f_ready=1, grants cycle 0,1,...,CH-1,0,...
//   A channel waits at most CH-1 grants.
// - Reset mid-operation: a pending f word is discarded (f_valid=0); the pointer returns to CH-1.
// - in_valid of a non-granted channel may drop at any time; no obligation is created until in_ready is seen.
// TESTING
// - Static pass-through: rst, mode=0, S=2, in_valid=4'b0100, I ch2=4'hA, f_ready=1
//   -> next cycle f=4'hA, f_ch=2, f_valid=1; in_ready=4'b0100 during the handshake.
// - Static miss: mode=0, S=1, in_valid=4'b1101 -> in_ready=0 and f_valid falls to 0 after drain.
// - Round-robin rotation: mode=1, all valid, ch k data=k+5, f_ready=1
//   -> f sequence 5,6,7,8,5; f_ch 0,1,2,3,0, one word per cycle.
// - Round-robin skip/wrap: ptr=2 (last grant ch2), in_valid=4'b0011 -> grant ch0 (wrap), then ch1.
// - Backpressure: f_valid=1, f_ready=0 for 3 cycles while in_valid, S and mode toggle
//   -> f, f_ch stable, in_ready=0; on f_ready=1 the next grant loads in the same cycle.
// - Reset mid-stream: rst=1 with f_valid=1, f_ready=0
//   -> next cycle f=0, f_valid=0, f_ch=0; first round-robin grant after reset is ch0 when all are valid.

Source files
------------

// File: rtl/mux_nto1_rr_reg_if.sv
// ---------------------------------------------------------------------------
// mux_nto1_rr_reg_if
// Bundles the producer-side channel handshake and the consumer-side output
// handshake of mux_nto1_rr_reg.
//   I        CH*WIDTH  packed channel words, channel k = I[k*WIDTH +: WIDTH]
//   in_valid CH        channel k offers a word
//   in_ready CH        one-hot (or zero): channel k's word is taken this cycle
//   f        WIDTH     registered output word
//   f_valid  1         f holds an unconsumed word
//   f_ch     SELW      channel that supplied f
//   f_ready  1         consumer accepts f this cycle
// Modports: slave = the mux itself, master = the environment around it.
// ---------------------------------------------------------------------------
interface mux_nto1_rr_reg_if #(
  parameter int WIDTH = 4,
  parameter int CH    = 4,
  parameter int SELW  = 2
);
  logic [CH*WIDTH-1:0] I;
  logic [CH-1:0]       in_valid;
  logic [CH-1:0]       in_ready;
  logic [WIDTH-1:0]    f;
  logic                f_valid;
  logic [SELW-1:0]     f_ch;
  logic                f_ready;

  modport master (
    output I, in_valid, f_ready,
    input  in_ready, f, f_valid, f_ch
  );

  modport slave (
    input  I, in_valid, f_ready,
    output in_ready, f, f_valid, f_ch
  );
endinterface

// File: rtl/mux_nto1_rr_reg.sv
// ---------------------------------------------------------------------------
// mux_nto1_rr_reg
// Registered N:1 channel multiplexer with per-channel valid/ready handshake
// and a one-deep output register. Selection is either static (channel S) or
// round-robin starting after the last granted channel.
//   clk   in   clock, rising edge
//   rst   in   synchronous active-high reset
//   mode  in   0 = static select by S, 1 = round-robin
//   S     in   static channel index (indices >= CH grant nothing)
//   bus   slave side of mux_nto1_rr_reg_if (channel inputs, output word)
// ---------------------------------------------------------------------------
module mux_nto1_rr_reg #(
  parameter int WIDTH = 4,
  parameter int CH    = 4,
  parameter int SELW  = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mode,
  input  logic [SELW-1:0] S,
  mux_nto1_rr_reg_if.slave bus
);

  // Index space reachable by a SELW-bit select; entries >= CH read as empty.
  localparam int NSEL = 1 << SELW;

  logic [NSEL-1:0]  valid_ext;
  logic [WIDTH-1:0] word_ext [NSEL];

  logic             load;
  logic             grant_valid;
  logic [SELW-1:0]  grant_idx;
  logic             xfer;

  logic [WIDTH-1:0] f_reg,       f_next;
  logic [SELW-1:0]  f_ch_reg,    f_ch_next;
  logic             f_valid_reg, f_valid_next;
  logic [SELW-1:0]  ptr_reg,     ptr_next;

  // Zero-extended valid vector keeps S >= CH (non-power-of-two CH) from
  // indexing past the real channels: those slots are never valid.
  assign valid_ext = NSEL'(bus.in_valid);

  genvar gi;
  generate
    for (gi = 0; gi < NSEL; gi++) begin : g_word
      if (gi < CH) begin : g_real
        assign word_ext[gi] = bus.I[gi*WIDTH +: WIDTH];
      end else begin : g_pad
        assign word_ext[gi] = '0;
      end
    end
  endgenerate

  // Output register can accept a word when empty or being drained now.
  assign load = !f_valid_reg || bus.f_ready;

  always_comb begin
    logic [SELW-1:0] cand;
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    if (!mode) begin
      grant_valid = valid_ext[S];
      grant_idx   = S;
    end else begin
      // Search ptr+1, ptr+2, ... wrapping; the first hit wins.
      for (int i = 1; i <= CH; i++) begin
        cand = SELW'((int'(ptr_reg) + i) % CH);
        if (!grant_valid && valid_ext[cand]) begin
          grant_valid = 1'b1;
          grant_idx   = cand;
        end
      end
    end
  end

  assign xfer = load && grant_valid && !rst;

  generate
    for (gi = 0; gi < CH; gi++) begin : g_ready
      assign bus.in_ready[gi] = xfer && (grant_idx == SELW'(gi));
    end
  endgenerate

  always_comb begin
    f_next       = f_reg;
    f_ch_next    = f_ch_reg;
    f_valid_next = f_valid_reg;
    ptr_next     = ptr_reg;
    if (xfer) begin
      // A load also covers the simultaneous-drain case: new word replaces old.
      f_next       = word_ext[grant_idx];
      f_ch_next    = grant_idx;
      f_valid_next = 1'b1;
      if (mode) begin
        ptr_next = grant_idx;
      end
    end else if (f_valid_reg && bus.f_ready) begin
      f_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      f_reg       <= '0;
      f_ch_reg    <= '0;
      f_valid_reg <= 1'b0;
      ptr_reg     <= SELW'(CH - 1);
    end else begin
      f_reg       <= f_next;
      f_ch_reg    <= f_ch_next;
      f_valid_reg <= f_valid_next;
      ptr_reg     <= ptr_next;
    end
  end

  assign bus.f       = f_reg;
  assign bus.f_ch    = f_ch_reg;
  assign bus.f_valid = f_valid_reg;

endmodule

// File: tb/tb_mux_nto1_rr_reg.sv
module tb_mux_nto1_rr_reg;

  logic       clk;
  logic       rst;
  logic       mode;
  logic [1:0] S;

  int checks;
  int failures;

  mux_nto1_rr_reg_if #(.WIDTH(4), .CH(4), .SELW(2)) bus ();

  mux_nto1_rr_reg #(.WIDTH(4), .CH(4), .SELW(2)) dut (
    .clk  (clk),
    .rst  (rst),
    .mode (mode),
    .S    (S),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; mode = 1'b1; S = 2'd0;
    bus.I = 16'h8765; bus.in_valid = 4'b1111; bus.f_ready = 1'b1;
    tick();
    tick();
    checks++;
    if (bus.in_ready !== 4'b0000) begin
      failures++; $display("FAIL reset_in_ready got=%b exp=0000", bus.in_ready);
    end
    checks++;
    if (bus.f !== 4'h0 || bus.f_valid !== 1'b0 || bus.f_ch !== 2'd0) begin
      failures++;
      $display("FAIL reset_state got f=%h v=%b ch=%0d exp f=0 v=0 ch=0", bus.f, bus.f_valid, bus.f_ch);
    end
    $display("txn reset: f=%h v=%b ch=%0d", bus.f, bus.f_valid, bus.f_ch);
    rst = 1'b0;
    bus.in_valid = 4'b0000;
  endtask

  task automatic test_static_pass();
    mode = 1'b0; S = 2'd2;
    bus.I = 16'h0A00; bus.in_valid = 4'b0100; bus.f_ready = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 4'b0100) begin
      failures++; $display("FAIL static_in_ready got=%b exp=0100", bus.in_ready);
    end
    tick();
    checks++;
    if (bus.f !== 4'hA || bus.f_ch !== 2'd2 || bus.f_valid !== 1'b1) begin
      failures++;
      $display("FAIL static_pass got f=%h ch=%0d v=%b exp f=a ch=2 v=1", bus.f, bus.f_ch, bus.f_valid);
    end
    $display("txn static pass: f=%h ch=%0d", bus.f, bus.f_ch);
  endtask

  task automatic test_static_miss();
    S = 2'd1; bus.in_valid = 4'b1101;
    #1;
    checks++;
    if (bus.in_ready !== 4'b0000) begin
      failures++; $display("FAIL static_miss_ready got=%b exp=0000", bus.in_ready);
    end
    tick();
    checks++;
    if (bus.f_valid !== 1'b0 || bus.f !== 4'hA || bus.f_ch !== 2'd2) begin
      failures++;
      $display("FAIL static_miss_drain got f=%h ch=%0d v=%b exp f=a ch=2 v=0", bus.f, bus.f_ch, bus.f_valid);
    end
    $display("txn static miss: v=%b", bus.f_valid);
    bus.in_valid = 4'b0000;
  endtask

  task automatic test_rr_rotation();
    logic [3:0] exp_ready;
    logic [3:0] exp_f;
    logic [1:0] exp_ch;
    mode = 1'b1; bus.I = 16'h8765; bus.in_valid = 4'b1111; bus.f_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      exp_ch    = 2'(k % 4);
      exp_ready = 4'b0001 << exp_ch;
      exp_f     = 4'(exp_ch) + 4'd5;
      #1;
      checks++;
      if (bus.in_ready !== exp_ready) begin
        failures++; $display("FAIL rr_ready[%0d] got=%b exp=%b", k, bus.in_ready, exp_ready);
      end
      tick();
      checks++;
      if (bus.f !== exp_f || bus.f_ch !== exp_ch || bus.f_valid !== 1'b1) begin
        failures++;
        $display("FAIL rr_word[%0d] got f=%h ch=%0d v=%b exp f=%h ch=%0d v=1", k, bus.f, bus.f_ch, bus.f_valid, exp_f, exp_ch);
      end
      $display("txn rr rotation %0d: f=%h ch=%0d", k, bus.f, bus.f_ch);
    end
    bus.in_valid = 4'b0000;
  endtask

  task automatic test_rr_wrap();
    mode = 1'b1; bus.f_ready = 1'b1;
    bus.in_valid = 4'b0100;
    tick();
    checks++;
    if (bus.f_ch !== 2'd2 || bus.f !== 4'h7) begin
      failures++; $display("FAIL wrap_setup got f=%h ch=%0d exp f=7 ch=2", bus.f, bus.f_ch);
    end
    bus.in_valid = 4'b0011;
    #1;
    checks++;
    if (bus.in_ready !== 4'b0001) begin
      failures++; $display("FAIL wrap_ready0 got=%b exp=0001", bus.in_ready);
    end
    tick();
    checks++;
    if (bus.f_ch !== 2'd0 || bus.f !== 4'h5) begin
      failures++; $display("FAIL wrap_ch0 got f=%h ch=%0d exp f=5 ch=0", bus.f, bus.f_ch);
    end
    $display("txn rr wrap: f=%h ch=%0d", bus.f, bus.f_ch);
    checks++;
    if (bus.in_ready !== 4'b0010) begin
      failures++; $display("FAIL wrap_ready1 got=%b exp=0010", bus.in_ready);
    end
    tick();
    checks++;
    if (bus.f_ch !== 2'd1 || bus.f !== 4'h6) begin
      failures++; $display("FAIL wrap_ch1 got f=%h ch=%0d exp f=6 ch=1", bus.f, bus.f_ch);
    end
    $display("txn rr wrap: f=%h ch=%0d", bus.f, bus.f_ch);
    bus.in_valid = 4'b0000;
  endtask

  task automatic test_backpressure();
    logic [3:0] valid_tab [3];
    logic [1:0] s_tab [3];
    logic       mode_tab [3];
    valid_tab = '{4'b1111, 4'b0101, 4'b1010};
    s_tab     = '{2'd0, 2'd1, 2'd2};
    mode_tab  = '{1'b1, 1'b0, 1'b1};
    mode = 1'b0; S = 2'd3; bus.in_valid = 4'b1000; bus.f_ready = 1'b1;
    tick();
    checks++;
    if (bus.f !== 4'h8 || bus.f_ch !== 2'd3 || bus.f_valid !== 1'b1) begin
      failures++; $display("FAIL bp_load got f=%h ch=%0d v=%b exp f=8 ch=3 v=1", bus.f, bus.f_ch, bus.f_valid);
    end
    bus.f_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.in_valid = valid_tab[k]; S = s_tab[k]; mode = mode_tab[k];
      #1;
      checks++;
      if (bus.in_ready !== 4'b0000) begin
        failures++; $display("FAIL bp_ready[%0d] got=%b exp=0000", k, bus.in_ready);
      end
      tick();
      checks++;
      if (bus.f !== 4'h8 || bus.f_ch !== 2'd3 || bus.f_valid !== 1'b1) begin
        failures++;
        $display("FAIL bp_hold[%0d] got f=%h ch=%0d v=%b exp f=8 ch=3 v=1", k, bus.f, bus.f_ch, bus.f_valid);
      end
      $display("txn stall %0d: f=%h ch=%0d", k, bus.f, bus.f_ch);
    end
    bus.f_ready = 1'b1; mode = 1'b0; S = 2'd1; bus.in_valid = 4'b0010;
    #1;
    checks++;
    if (bus.in_ready !== 4'b0010) begin
      failures++; $display("FAIL bp_release_ready got=%b exp=0010", bus.in_ready);
    end
    tick();
    checks++;
    if (bus.f !== 4'h6 || bus.f_ch !== 2'd1 || bus.f_valid !== 1'b1) begin
      failures++; $display("FAIL bp_release got f=%h ch=%0d v=%b exp f=6 ch=1 v=1", bus.f, bus.f_ch, bus.f_valid);
    end
    $display("txn release: f=%h ch=%0d", bus.f, bus.f_ch);
    bus.in_valid = 4'b0000;
    tick();
    checks++;
    if (bus.f_valid !== 1'b0 || bus.f !== 4'h6) begin
      failures++; $display("FAIL bp_drain got f=%h v=%b exp f=6 v=0", bus.f, bus.f_valid);
    end
  endtask

  task automatic test_reset_mid();
    mode = 1'b0; S = 2'd0; bus.in_valid = 4'b0001; bus.f_ready = 1'b1;
    tick();
    bus.f_ready = 1'b0; bus.in_valid = 4'b1111; mode = 1'b1;
    checks++;
    if (bus.f_valid !== 1'b1 || bus.f !== 4'h5) begin
      failures++; $display("FAIL mid_setup got f=%h v=%b exp f=5 v=1", bus.f, bus.f_valid);
    end
    rst = 1'b1;
    bus.f_ready = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 4'b0000) begin
      failures++; $display("FAIL mid_rst_ready got=%b exp=0000", bus.in_ready);
    end
    bus.f_ready = 1'b0;
    tick();
    checks++;
    if (bus.f !== 4'h0 || bus.f_valid !== 1'b0 || bus.f_ch !== 2'd0) begin
      failures++;
      $display("FAIL mid_rst_state got f=%h v=%b ch=%0d exp f=0 v=0 ch=0", bus.f, bus.f_valid, bus.f_ch);
    end
    $display("txn reset mid-stream: f=%h v=%b", bus.f, bus.f_valid);
    rst = 1'b0; bus.f_ready = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 4'b0001) begin
      failures++; $display("FAIL mid_first_ready got=%b exp=0001", bus.in_ready);
    end
    tick();
    checks++;
    if (bus.f !== 4'h5 || bus.f_ch !== 2'd0 || bus.f_valid !== 1'b1) begin
      failures++; $display("FAIL mid_first_grant got f=%h ch=%0d v=%b exp f=5 ch=0 v=1", bus.f, bus.f_ch, bus.f_valid);
    end
    $display("txn first grant after reset: f=%h ch=%0d", bus.f, bus.f_ch);
    bus.in_valid = 4'b0000;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1; mode = 1'b0; S = 2'd0;
    bus.I = '0; bus.in_valid = '0; bus.f_ready = 1'b0;
    test_reset();
    test_static_pass();
    test_static_miss();
    test_rr_rotation();
    test_rr_wrap();
    test_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
